// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multicycle control unit: state
// encoding, opcode map and datapath mux select codes.
package ctrl_pkg;

  typedef enum logic [4:0] {
    S_FETCH    = 5'd0,
    S_DECODE   = 5'd1,
    S_R_EXEC   = 5'd2,
    S_R_WB     = 5'd3,
    S_BER      = 5'd4,
    S_MEM_ADDR = 5'd5,
    S_LOAD_RD  = 5'd6,
    S_LOAD_WB  = 5'd7,
    S_STORE    = 5'd8,
    S_SHIFT    = 5'd9,
    S_SHIFT_WB = 5'd10,
    S_LPC_CALC = 5'd11,
    S_LPC_WB   = 5'd12,
    S_SPC_CALC = 5'd13,
    S_SPC_WB   = 5'd14,
    S_LDC      = 5'd15,
    S_ADDC     = 5'd16,
    S_LC       = 5'd17,
    S_TRAP     = 5'd18
  } state_t;

  // Opcodes 0..OP_R_LAST are R-type; OP_ILLEGAL and above trap.
  localparam int OP_R_LAST  = 5;
  localparam int OP_BER     = 6;
  localparam int OP_LPC     = 7;
  localparam int OP_LW      = 8;
  localparam int OP_SW      = 9;
  localparam int OP_SLL     = 10;
  localparam int OP_SRL     = 11;
  localparam int OP_ADDC    = 12;
  localparam int OP_LC      = 13;
  localparam int OP_SPC     = 14;
  localparam int OP_ILLEGAL = 15;

  localparam int ALUA_PC    = 0;
  localparam int ALUA_REG_A = 1;
  localparam int ALUA_SHIFT = 2;
  localparam int ALUA_C     = 3;
  localparam int ALUA_LC    = 4;

  localparam int ALUB_REG_B = 0;
  localparam int ALUB_ONE   = 1;
  localparam int ALUB_IMM   = 2;

  localparam int PCSRC_ALUOUT = 0;
  localparam int PCSRC_ALU    = 1;
  localparam int PCSRC_REG    = 2;

  localparam int SHIN_REG_B = 0;
  localparam int SHIN_IMM   = 1;
  localparam int SHIN_ALU   = 2;

  localparam int SHCTL_NONE  = 0;
  localparam int SHCTL_SHIFT = 1;
  localparam int SHCTL_PASS  = 2;

endpackage

// File: rtl/multicycle_op_decode.sv
// Combinational opcode dispatch: picks the state entered after DECODE and
// flags opcodes outside the legal map.
module multicycle_op_decode
  import ctrl_pkg::*;
#(
  parameter int OP_W = 4
) (
  input  logic [OP_W-1:0] op,
  output state_t          dispatch,
  output logic            illegal
);

  int unsigned op_val;

  always_comb begin
    op_val   = 32'(op);
    illegal  = (op_val >= OP_ILLEGAL);
    dispatch = S_TRAP;
    if (op_val <= OP_R_LAST)                        dispatch = S_R_EXEC;
    else if (op_val == OP_BER)                      dispatch = S_BER;
    else if (op_val == OP_LPC)                      dispatch = S_LPC_CALC;
    else if (op_val == OP_SPC)                      dispatch = S_SPC_CALC;
    else if (op_val == OP_LW || op_val == OP_SW)    dispatch = S_MEM_ADDR;
    else if (op_val == OP_SLL || op_val == OP_SRL)  dispatch = S_SHIFT;
    else if (op_val == OP_ADDC || op_val == OP_LC)  dispatch = S_LDC;
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle control unit: state register, next-state logic and Moore
// output decode for the datapath mux selects and write strobes.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int OP_W      = 4,
  parameter int ALU_SEL_W = 3,
  parameter int SEL_W     = 2
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic [OP_W-1:0]      op,
  input  logic                 mem_ready,
  input  logic                 exc_ack,
  output logic                 mem_req,
  output logic                 ReadAddr,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 PCWriteCond,
  output logic                 RegWrite,
  output logic                 RegRead,
  output logic                 MemWrite,
  output logic                 MDWrite,
  output logic                 AWrite,
  output logic                 BWrite,
  output logic                 CWrite,
  output logic                 ALUOutWrite,
  output logic                 EPCWrite,
  output logic [ALU_SEL_W-1:0] ALUA,
  output logic [SEL_W-1:0]     ALUB,
  output logic [SEL_W-1:0]     PCSource,
  output logic [SEL_W-1:0]     ShifterInput,
  output logic [SEL_W-1:0]     ShifterControl,
  output logic                 ALUControl,
  output logic                 CSource,
  output logic                 RegDest,
  output logic                 MemToReg,
  output logic                 ShifterLeft,
  output logic                 trap,
  output logic [4:0]           state_o
);

  state_t state, state_next;
  state_t dispatch;
  logic   illegal;
  logic   trap_first;

  multicycle_op_decode #(.OP_W(OP_W)) u_op_decode (
    .op       (op),
    .dispatch (dispatch),
    .illegal  (illegal)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state      <= S_FETCH;
      trap_first <= 1'b0;
    end else begin
      state      <= state_next;
      trap_first <= (state_next == S_TRAP) && (state != S_TRAP);
    end
  end

  // Memory handshake: mem_req stays high for the whole FETCH/LOAD_RD/STORE
  // visit; the request completes, and the state advances, on the edge
  // closing a cycle in which mem_ready is high. mem_ready is ignored elsewhere.
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:    if (mem_ready) state_next = S_DECODE;
      S_DECODE:   state_next = illegal ? S_TRAP : dispatch;
      S_R_EXEC:   state_next = S_R_WB;
      S_MEM_ADDR: state_next = (op == OP_W'(OP_LW)) ? S_LOAD_RD : S_STORE;
      S_LOAD_RD:  if (mem_ready) state_next = S_LOAD_WB;
      S_STORE:    if (mem_ready) state_next = S_FETCH;
      S_SHIFT:    state_next = S_SHIFT_WB;
      S_LPC_CALC: state_next = S_LPC_WB;
      S_SPC_CALC: state_next = S_SPC_WB;
      S_LDC:      state_next = (op == OP_W'(OP_ADDC)) ? S_ADDC : S_LC;
      S_TRAP:     if (exc_ack) state_next = S_FETCH;
      default:    state_next = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req        = 1'b0;
    ReadAddr       = 1'b0;
    IRWrite        = 1'b0;
    PCWrite        = 1'b0;
    PCWriteCond    = 1'b0;
    RegWrite       = 1'b0;
    RegRead        = 1'b0;
    MemWrite       = 1'b0;
    MDWrite        = 1'b0;
    AWrite         = 1'b0;
    BWrite         = 1'b0;
    CWrite         = 1'b0;
    ALUOutWrite    = 1'b0;
    EPCWrite       = 1'b0;
    ALUA           = ALU_SEL_W'(ALUA_PC);
    ALUB           = SEL_W'(ALUB_REG_B);
    PCSource       = SEL_W'(PCSRC_ALUOUT);
    ShifterInput   = SEL_W'(SHIN_REG_B);
    ShifterControl = SEL_W'(SHCTL_NONE);
    ALUControl     = 1'b0;
    CSource        = 1'b0;
    RegDest        = 1'b0;
    MemToReg       = 1'b0;
    ShifterLeft    = 1'b0;
    trap           = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        ALUB       = SEL_W'(ALUB_ONE);
        ALUControl = 1'b1;
        PCSource   = SEL_W'(PCSRC_ALU);
        IRWrite    = mem_ready;
        PCWrite    = mem_ready;
      end
      S_DECODE: begin
        RegRead = 1'b1;
        AWrite  = 1'b1;
        BWrite  = 1'b1;
      end
      S_R_EXEC: begin
        ALUA        = ALU_SEL_W'(ALUA_REG_A);
        ALUB        = SEL_W'(ALUB_ONE);
        ALUOutWrite = 1'b1;
        CWrite      = 1'b1;
      end
      S_BER: begin
        ALUA        = ALU_SEL_W'(ALUA_REG_A);
        ALUB        = SEL_W'(ALUB_ONE);
        PCWriteCond = 1'b1;
      end
      S_MEM_ADDR: begin
        ALUA           = ALU_SEL_W'(ALUA_REG_A);
        ALUB           = SEL_W'(ALUB_IMM);
        ALUControl     = 1'b1;
        ShifterControl = SEL_W'(SHCTL_PASS);
        ALUOutWrite    = 1'b1;
      end
      S_LOAD_RD: begin
        ReadAddr = 1'b1;
        mem_req  = 1'b1;
        MDWrite  = mem_ready;
      end
      S_LOAD_WB: begin
        MemToReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_STORE: begin
        ReadAddr = 1'b1;
        mem_req  = 1'b1;
        MemWrite = 1'b1;
      end
      S_SHIFT: begin
        ALUA           = ALU_SEL_W'(ALUA_SHIFT);
        ALUB           = SEL_W'(ALUB_IMM);
        ALUControl     = 1'b1;
        ShifterInput   = SEL_W'(SHIN_ALU);
        ShifterControl = SEL_W'(SHCTL_SHIFT);
        ShifterLeft    = (op != OP_W'(OP_SRL));
        ALUOutWrite    = 1'b1;
      end
      S_LPC_CALC: begin
        ALUB         = SEL_W'(ALUB_IMM);
        ALUControl   = 1'b1;
        ShifterInput = SEL_W'(SHIN_IMM);
        ALUOutWrite  = 1'b1;
      end
      S_SPC_CALC: begin
        ALUA         = ALU_SEL_W'(ALUA_C);
        ALUB         = SEL_W'(ALUB_IMM);
        ShifterInput = SEL_W'(SHIN_IMM);
        ALUOutWrite  = 1'b1;
      end
      S_SPC_WB: begin
        PCSource = SEL_W'(PCSRC_REG);
        PCWrite  = 1'b1;
      end
      S_LDC: CWrite = 1'b1;
      S_ADDC: begin
        ALUA           = ALU_SEL_W'(ALUA_SHIFT);
        ALUB           = SEL_W'(ALUB_IMM);
        ShifterInput   = SEL_W'(SHIN_IMM);
        ShifterControl = SEL_W'(SHCTL_PASS);
        RegWrite       = 1'b1;
      end
      S_LC: begin
        ALUA           = ALU_SEL_W'(ALUA_LC);
        ALUB           = SEL_W'(ALUB_IMM);
        ShifterInput   = SEL_W'(SHIN_IMM);
        ShifterControl = SEL_W'(SHCTL_PASS);
        RegWrite       = 1'b1;
        PCWrite        = 1'b1;
      end
      S_R_WB, S_SHIFT_WB, S_LPC_WB: RegWrite = 1'b1;
      S_TRAP: begin
        trap     = 1'b1;
        EPCWrite = trap_first;
      end
      default: ;
    endcase
  end

  assign state_o = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed per-cycle vector bench for multicycle_controller: each record
// gives the inputs for one cycle plus the state and strobes expected then.
module tb_multicycle_controller;
  import ctrl_pkg::*;

  logic       CLK = 1'b0;
  logic       Reset = 1'b1;
  logic [3:0] op = '0;
  logic       mem_ready = 1'b0;
  logic       exc_ack = 1'b0;
  logic       mem_req, ReadAddr, IRWrite, PCWrite, PCWriteCond, RegWrite;
  logic       RegRead, MemWrite, MDWrite, AWrite, BWrite, CWrite;
  logic       ALUOutWrite, EPCWrite, ALUControl, CSource, RegDest;
  logic       MemToReg, ShifterLeft, trap;
  logic [2:0] ALUA;
  logic [1:0] ALUB, PCSource, ShifterInput, ShifterControl;
  logic [4:0] state_o;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_controller dut (
    .CLK(CLK), .Reset(Reset), .op(op), .mem_ready(mem_ready), .exc_ack(exc_ack),
    .mem_req(mem_req), .ReadAddr(ReadAddr), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .RegWrite(RegWrite), .RegRead(RegRead),
    .MemWrite(MemWrite), .MDWrite(MDWrite), .AWrite(AWrite), .BWrite(BWrite),
    .CWrite(CWrite), .ALUOutWrite(ALUOutWrite), .EPCWrite(EPCWrite),
    .ALUA(ALUA), .ALUB(ALUB), .PCSource(PCSource), .ShifterInput(ShifterInput),
    .ShifterControl(ShifterControl), .ALUControl(ALUControl), .CSource(CSource),
    .RegDest(RegDest), .MemToReg(MemToReg), .ShifterLeft(ShifterLeft),
    .trap(trap), .state_o(state_o)
  );

  always #5 CLK = ~CLK;

  localparam logic [14:0] B_MEMREQ = 15'h0001;
  localparam logic [14:0] B_RDADDR = 15'h0002;
  localparam logic [14:0] B_IRW    = 15'h0004;
  localparam logic [14:0] B_PCW    = 15'h0008;
  localparam logic [14:0] B_PCWC   = 15'h0010;
  localparam logic [14:0] B_REGW   = 15'h0020;
  localparam logic [14:0] B_REGR   = 15'h0040;
  localparam logic [14:0] B_MEMW   = 15'h0080;
  localparam logic [14:0] B_MDW    = 15'h0100;
  localparam logic [14:0] B_AW     = 15'h0200;
  localparam logic [14:0] B_BW     = 15'h0400;
  localparam logic [14:0] B_CW     = 15'h0800;
  localparam logic [14:0] B_ALUOW  = 15'h1000;
  localparam logic [14:0] B_EPCW   = 15'h2000;
  localparam logic [14:0] B_TRAP   = 15'h4000;
  localparam logic [14:0] F_GO     = B_MEMREQ | B_IRW | B_PCW;
  localparam logic [14:0] F_DEC    = B_REGR | B_AW | B_BW;
  localparam logic [14:0] F_ST     = B_MEMREQ | B_RDADDR | B_MEMW;

  typedef struct {
    logic        rst;
    logic [3:0]  op;
    logic        mr;
    logic        ack;
    logic        chk;
    state_t      st;
    logic [14:0] strb;
  } vec_t;

  vec_t vq[$];

  function automatic void add(logic rst, logic [3:0] o, logic mr, logic ack,
                              logic chk, state_t st, logic [14:0] strb);
    vec_t v;
    v.rst = rst; v.op = o; v.mr = mr; v.ack = ack; v.chk = chk; v.st = st; v.strb = strb;
    vq.push_back(v);
  endfunction

  // Expected mux selects per state:
  // {ALUA, ALUB, PCSource, ShifterInput, ShifterControl, ALUControl,
  //  CSource, RegDest, MemToReg, ShifterLeft}
  function automatic logic [15:0] ref_sel(state_t s, logic [3:0] o);
    case (s)
      S_FETCH:    ref_sel = {3'd0, 2'd1, 2'd1, 2'd0, 2'd0, 5'b10000};
      S_R_EXEC:   ref_sel = {3'd1, 2'd1, 2'd0, 2'd0, 2'd0, 5'b00000};
      S_BER:      ref_sel = {3'd1, 2'd1, 2'd0, 2'd0, 2'd0, 5'b00000};
      S_MEM_ADDR: ref_sel = {3'd1, 2'd2, 2'd0, 2'd0, 2'd2, 5'b10000};
      S_LOAD_WB:  ref_sel = {3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 5'b00010};
      S_SHIFT:    ref_sel = {3'd2, 2'd2, 2'd0, 2'd2, 2'd1, 4'b1000, (o != 4'd11)};
      S_LPC_CALC: ref_sel = {3'd0, 2'd2, 2'd0, 2'd1, 2'd0, 5'b10000};
      S_SPC_CALC: ref_sel = {3'd3, 2'd2, 2'd0, 2'd1, 2'd0, 5'b00000};
      S_SPC_WB:   ref_sel = {3'd0, 2'd0, 2'd2, 2'd0, 2'd0, 5'b00000};
      S_ADDC:     ref_sel = {3'd2, 2'd2, 2'd0, 2'd1, 2'd2, 5'b00000};
      S_LC:       ref_sel = {3'd4, 2'd2, 2'd0, 2'd1, 2'd2, 5'b00000};
      default:    ref_sel = 16'h0000;
    endcase
  endfunction

  task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  logic [14:0] act_strb;
  logic [15:0] act_sel;

  initial begin
    // reset for two cycles, then R-type with no waits
    add(1, 0, 1, 0, 0, S_FETCH,    '0);
    add(1, 0, 1, 0, 1, S_FETCH,    F_GO);
    add(0, 0, 1, 0, 1, S_FETCH,    F_GO);
    add(0, 0, 1, 0, 1, S_DECODE,   F_DEC);
    add(0, 0, 1, 0, 1, S_R_EXEC,   B_ALUOW | B_CW);
    add(0, 0, 1, 0, 1, S_R_WB,     B_REGW);
    // FETCH wait, then LW with three LOAD_RD waits
    add(0, 8, 0, 0, 1, S_FETCH,    B_MEMREQ);
    add(0, 8, 1, 0, 1, S_FETCH,    F_GO);
    add(0, 8, 1, 0, 1, S_DECODE,   F_DEC);
    add(0, 8, 1, 0, 1, S_MEM_ADDR, B_ALUOW);
    add(0, 8, 0, 0, 1, S_LOAD_RD,  B_MEMREQ | B_RDADDR);
    add(0, 8, 0, 0, 1, S_LOAD_RD,  B_MEMREQ | B_RDADDR);
    add(0, 8, 0, 0, 1, S_LOAD_RD,  B_MEMREQ | B_RDADDR);
    add(0, 8, 1, 0, 1, S_LOAD_RD,  B_MEMREQ | B_RDADDR | B_MDW);
    add(0, 8, 1, 0, 1, S_LOAD_WB,  B_REGW);
    // SW with two STORE waits
    add(0, 9, 1, 0, 1, S_FETCH,    F_GO);
    add(0, 9, 1, 0, 1, S_DECODE,   F_DEC);
    add(0, 9, 1, 0, 1, S_MEM_ADDR, B_ALUOW);
    add(0, 9, 0, 0, 1, S_STORE,    F_ST);
    add(0, 9, 0, 0, 1, S_STORE,    F_ST);
    add(0, 9, 1, 0, 1, S_STORE,    F_ST);
    // BER, with mem_ready low in BER to show it is ignored
    add(0, 6, 1, 0, 1, S_FETCH,    F_GO);
    add(0, 6, 1, 0, 1, S_DECODE,   F_DEC);
    add(0, 6, 0, 0, 1, S_BER,      B_PCWC);
    // SLL then SRL
    add(0, 10, 1, 0, 1, S_FETCH,    F_GO);
    add(0, 10, 1, 0, 1, S_DECODE,   F_DEC);
    add(0, 10, 1, 0, 1, S_SHIFT,    B_ALUOW);
    add(0, 10, 1, 0, 1, S_SHIFT_WB, B_REGW);
    add(0, 11, 1, 0, 1, S_FETCH,    F_GO);
    add(0, 11, 1, 0, 1, S_DECODE,   F_DEC);
    add(0, 11, 1, 0, 1, S_SHIFT,    B_ALUOW);
    add(0, 11, 1, 0, 1, S_SHIFT_WB, B_REGW);
    // LPC, SPC
    add(0, 7, 1, 0, 1, S_FETCH,    F_GO);
    add(0, 7, 1, 0, 1, S_DECODE,   F_DEC);
    add(0, 7, 1, 0, 1, S_LPC_CALC, B_ALUOW);
    add(0, 7, 1, 0, 1, S_LPC_WB,   B_REGW);
    add(0, 14, 1, 0, 1, S_FETCH,    F_GO);
    add(0, 14, 1, 0, 1, S_DECODE,   F_DEC);
    add(0, 14, 1, 0, 1, S_SPC_CALC, B_ALUOW);
    add(0, 14, 1, 0, 1, S_SPC_WB,   B_PCW);
    add(0, 12, 0, 0, 1, S_FETCH,    B_MEMREQ);
    // ADDC, LC
    add(0, 12, 1, 0, 1, S_FETCH,    F_GO);
    add(0, 12, 1, 0, 1, S_DECODE,   F_DEC);
    add(0, 12, 1, 0, 1, S_LDC,      B_CW);
    add(0, 12, 1, 0, 1, S_ADDC,     B_REGW);
    add(0, 13, 1, 0, 1, S_FETCH,    F_GO);
    add(0, 13, 1, 0, 1, S_DECODE,   F_DEC);
    add(0, 13, 1, 0, 1, S_LDC,      B_CW);
    add(0, 13, 1, 0, 1, S_LC,       B_REGW | B_PCW);
    // illegal opcode: trap held five cycles, then acknowledged
    add(0, 15, 1, 0, 1, S_FETCH,    F_GO);
    add(0, 15, 1, 0, 1, S_DECODE,   F_DEC);
    add(0, 15, 1, 0, 1, S_TRAP,     B_TRAP | B_EPCW);
    add(0, 15, 1, 0, 1, S_TRAP,     B_TRAP);
    add(0, 15, 1, 0, 1, S_TRAP,     B_TRAP);
    add(0, 15, 1, 0, 1, S_TRAP,     B_TRAP);
    add(0, 15, 1, 0, 1, S_TRAP,     B_TRAP);
    add(0, 15, 1, 1, 1, S_TRAP,     B_TRAP);
    // exc_ack held high from FETCH: EPCWrite still pulses once
    add(0, 15, 1, 1, 1, S_FETCH,    F_GO);
    add(0, 15, 1, 1, 1, S_DECODE,   F_DEC);
    add(0, 15, 1, 1, 1, S_TRAP,     B_TRAP | B_EPCW);
    // reset during a STORE wait, then reset beating mem_ready in FETCH
    add(0, 9, 1, 0, 1, S_FETCH,    F_GO);
    add(0, 9, 1, 0, 1, S_DECODE,   F_DEC);
    add(0, 9, 1, 0, 1, S_MEM_ADDR, B_ALUOW);
    add(1, 9, 0, 0, 1, S_STORE,    F_ST);
    add(0, 9, 0, 0, 1, S_FETCH,    B_MEMREQ);
    add(1, 0, 1, 0, 1, S_FETCH,    F_GO);
    add(0, 0, 1, 0, 1, S_FETCH,    F_GO);
    add(0, 0, 1, 0, 1, S_DECODE,   F_DEC);

    foreach (vq[i]) begin
      @(negedge CLK);
      Reset     = vq[i].rst;
      op        = vq[i].op;
      mem_ready = vq[i].mr;
      exc_ack   = vq[i].ack;
      #1;
      if (vq[i].chk) begin
        act_strb = {trap, EPCWrite, ALUOutWrite, CWrite, BWrite, AWrite, MDWrite,
                    MemWrite, RegRead, RegWrite, PCWriteCond, PCWrite, IRWrite,
                    ReadAddr, mem_req};
        act_sel  = {ALUA, ALUB, PCSource, ShifterInput, ShifterControl, ALUControl,
                    CSource, RegDest, MemToReg, ShifterLeft};
        check("state", i, 32'(state_o), 32'(vq[i].st));
        check("strobes", i, 32'(act_strb), 32'(vq[i].strb));
        check("selects", i, 32'(act_sel), 32'(ref_sel(vq[i].st, vq[i].op)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Parametrised multicycle control unit for the processor datapath. It sequences fetch, decode, execute, memory and writeback for the full 4-bit opcode map and drives every datapath mux select and write strobe. Unlike the first-generation controller, it waits on a memory ready handshake, decodes every opcode, including LPC/SPC, and enters a trap state on illegal opcodes until software acknowledges. It sits between the IR opcode field and the datapath, with no datapath state of its own.

## Interface
Parameters:
- OP_W, 4: opcode width; opcodes ≥ 15 are illegal.
- ALU_SEL_W, 3: width of ALUA select (values 0–4).
- SEL_W, 2: width of ALUB, PCSource, ShifterInput and ShifterControl selects.

Ports:
- CLK  in  1  single clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high; state forced to FETCH on the next CLK edge.
- op  in  OP_W  opcode from the IR, sampled only in DECODE and the later states of the instruction.
- mem_ready  in  1  memory completes the current request this cycle.
- exc_ack  in  1  releases the controller from TRAP.
- mem_req  out  1  memory request active; asserted in FETCH, LOAD_RD and STORE.
- ReadAddr  out  1  0 = PC address, 1 = ALUOut address.
- IRWrite, PCWrite, PCWriteCond, RegWrite, RegRead, MemWrite, MDWrite  out  1 each  strobes.
- AWrite, BWrite, CWrite, ALUOutWrite, EPCWrite  out  1 each  register enables.
- ALUA  out  ALU_SEL_W; ALUB, PCSource, ShifterInput, ShifterControl  out  SEL_W each  mux selects.
- ALUControl, CSource, RegDest, MemToReg, ShifterLeft  out  1 each  selects.
- trap  out  1  high while in TRAP.
- state_o  out  5  current state encoding, for debug.

## Operation
- Moore machine: outputs are a pure decode of the state register, except that the strobes marked *qual* are ANDed with mem_ready.
- Every output not listed for a state is 0. No latched or stale values are allowed.
- States and outputs:
  - FETCH: mem_req, ALUB=1, ALUControl=1, PCSource=1; IRWrite and PCWrite *qual*.
  - DECODE: RegRead, AWrite, BWrite.
  - R_EXEC: ALUA=1, ALUB=1, ALUOutWrite, CWrite.
  - R_WB: RegWrite.
  - BER: ALUA=1, ALUB=1, PCWriteCond.
  - MEM_ADDR: ALUA=1, ALUB=2, ALUControl=1, ShifterControl=2, ALUOutWrite.
  - LOAD_RD: ReadAddr, mem_req; MDWrite *qual*.
  - LOAD_WB: MemToReg, RegWrite.
  - STORE: ReadAddr, mem_req, MemWrite.
  - SHIFT: ALUA=2, ALUB=2, ALUControl=1, ShifterInput=2, ShifterControl=1, ShifterLeft=(op==11 ? 0 : 1), ALUOutWrite.
  - SHIFT_WB: RegWrite.
  - LPC_CALC: ALUB=2, ALUControl=1, ShifterInput=1, ALUOutWrite.
  - LPC_WB: RegWrite.
  - SPC_CALC: ALUA=3, ALUB=2, ShifterInput=1, ALUOutWrite.
  - SPC_WB: PCSource=2, PCWrite.
  - LDC: CWrite.
  - ADDC: ALUA=2, ALUB=2, ShifterInput=1, ShifterControl=2, RegWrite.
  - LC: ALUA=4, ALUB=2, ShifterInput=1, ShifterControl=2, RegWrite, PCWrite.
  - TRAP: trap; EPCWrite in the first TRAP cycle only.
- Decode map, leaving DECODE:
  - op 0–5 → R_EXEC; op 6 → BER.
  - op 7 → LPC_CALC; op 14 → SPC_CALC.
  - op 8, 9 → MEM_ADDR; op 10, 11 → SHIFT; op 12, 13 → LDC.
  - op ≥ 15 → TRAP.
- Other transitions:
  - MEM_ADDR → LOAD_RD when op==8, else STORE.
  - LOAD_RD → LOAD_WB; STORE → FETCH.
  - LDC → ADDC when op==12, else LC.
  - All \*_WB, BER, ADDC and LC → FETCH.
  - TRAP → FETCH on exc_ack.

## Timing
- Reset: the next state is FETCH. Outputs after reset are the FETCH decode, so mem_req=1, IRWrite=PCWrite=mem_ready, and all other strobes are 0.
- Memory states (FETCH, LOAD_RD, STORE) hold until mem_ready=1 and advance on that edge.
- mem_req stays high throughout the wait. Qualified strobes pulse exactly in the mem_ready cycle.
- Minimum cycles per instruction:
  - R-type 4, BER 3, LW 5, SW 4.
  - Shift 4, LPC 4, SPC 4, ADDC 4, LC 4.
  - Each memory state adds one cycle per mem_ready=0 wait cycle.
- mem_ready outside FETCH, LOAD_RD and STORE is ignored.
- exc_ack is honoured only in TRAP. EPCWrite is a single-cycle pulse even if exc_ack is held high.
- Reset mid-instruction, including during a STORE wait, means the next state is FETCH. MemWrite drops the cycle after the edge, and no writeback occurs.
- Reset has priority over mem_ready and exc_ack.

## Structure
- ctrl_pkg holds:
  - the state enum (5-bit encoding),
  - opcode constants OP_BER, OP_LPC, OP_LW, OP_SW, OP_SLL, OP_SRL, OP_ADDC, OP_LC and OP_SPC,
  - the ALUA, ALUB, PCSource and Shifter select constants.
- Sub-module multicycle_op_decode is combinational and maps op to a dispatch state and an illegal flag. The top level holds the state register, next-state logic and output decode.

## Test plan
- Reset high for 2 cycles, then op=0 with mem_ready=1 → state_o sequence FETCH, DECODE, R_EXEC, R_WB, FETCH; RegWrite high only in R_WB.
- LW (op=8) with mem_ready low for 3 cycles in LOAD_RD → 8 cycles total; MDWrite pulses once, coincident with mem_ready.
- SW (op=9) → MemWrite and ReadAddr high through STORE until mem_ready; RegWrite never asserted.
- op=15 → TRAP, EPCWrite a 1-cycle pulse, trap stays high with exc_ack=0 for 5 cycles; exc_ack=1 → FETCH next cycle.
- SPC (op=14) → SPC_WB asserts PCSource=2 and PCWrite for exactly 1 cycle.
- Reset asserted during a STORE wait → FETCH next cycle; MemWrite low from that cycle onward.
